// File: rtl/sig_mix.sv
// sig_mix: two-stage complex mixer joining an LO stream with an I/Q stream.
// Define SIG_MIX_CONJ_EN to multiply by conj(lo) (downshift) instead of lo (upshift).
module sig_mix #(
  parameter  int n_bits = 8,
  parameter  int i_bits = 8,
  localparam int o_bits = n_bits + i_bits + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lo_tvalid,
  input  logic signed [n_bits-1:0] lo_cos,
  input  logic signed [n_bits-1:0] lo_sin,
  output logic                     lo_tready,
  input  logic                     x_tvalid,
  input  logic signed [i_bits-1:0] xi,
  input  logic signed [i_bits-1:0] xq,
  output logic                     x_tready,
  output logic                     y_tvalid,
  output logic signed [o_bits-1:0] yi,
  output logic signed [o_bits-1:0] yq,
  input  logic                     y_tready
);

  localparam int p_bits = n_bits + i_bits;

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic adv1, adv2;
  logic join_ok;

  logic signed [p_bits-1:0] ic_q, qs_q, is_q, qc_q;
  logic signed [p_bits-1:0] ic_d, qs_d, is_d, qc_d;

  logic signed [o_bits-1:0] ic_x, qs_x, is_x, qc_x;
  logic signed [o_bits-1:0] yi_q, yi_d;
  logic signed [o_bits-1:0] yq_q, yq_d;

  // Handshake: a stage advances when it is empty or the next stage advances
  always_comb begin
    adv2      = !v2_q | y_tready;
    adv1      = !v1_q | adv2;
    join_ok   = lo_tvalid & x_tvalid & adv1 & !reset;
    x_tready  = lo_tvalid & adv1 & !reset;
    lo_tready = x_tvalid & adv1 & !reset;
    v1_d      = adv1 ? (lo_tvalid & x_tvalid) : v1_q;
    v2_d      = adv2 ? v1_q : v2_q;
  end

  // Stage-1 products at full n_bits+i_bits width
  always_comb begin
    ic_d = p_bits'(xi) * p_bits'(lo_cos);
    qs_d = p_bits'(xq) * p_bits'(lo_sin);
    is_d = p_bits'(xi) * p_bits'(lo_sin);
    qc_d = p_bits'(xq) * p_bits'(lo_cos);
  end

  // Stage-1 product registers, qualified only by v1 so left unreset
  always_ff @(posedge clk) begin
    if (join_ok) begin
      ic_q <= ic_d;
      qs_q <= qs_d;
      is_q <= is_d;
      qc_q <= qc_d;
    end
  end

  // Stage-2 sums, sign-extended by one bit so they never overflow
  always_comb begin
    ic_x = o_bits'(ic_q);
    qs_x = o_bits'(qs_q);
    is_x = o_bits'(is_q);
    qc_x = o_bits'(qc_q);
    yi_d = yi_q;
    yq_d = yq_q;
    if (adv2 && v1_q) begin
`ifdef SIG_MIX_CONJ_EN
      yi_d = ic_x + qs_x;
      yq_d = qc_x - is_x;
`else
      yi_d = ic_x - qs_x;
      yq_d = is_x + qc_x;
`endif
    end
  end

  // Valid flags and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      yi_q <= '0;
      yq_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      yi_q <= yi_d;
      yq_q <= yq_d;
    end
  end

  assign y_tvalid = v2_q;
  assign yi       = yi_q;
  assign yq       = yq_q;

endmodule

// File: tb/tb_sig_mix.sv
// tb_sig_mix: directed and random checks of sig_mix against a queue model.
// Expected mixer outputs follow SIG_MIX_CONJ_EN the same way as the design.
module tb_sig_mix;

  localparam int N = 8;
  localparam int I = 8;
  localparam int O = N + I + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                lo_tvalid;
  logic signed [N-1:0] lo_cos;
  logic signed [N-1:0] lo_sin;
  logic                lo_tready;
  logic                x_tvalid;
  logic signed [I-1:0] xi;
  logic signed [I-1:0] xq;
  logic                x_tready;
  logic                y_tvalid;
  logic signed [O-1:0] yi;
  logic signed [O-1:0] yq;
  logic                y_tready;

  sig_mix #(.n_bits(N), .i_bits(I)) dut (
    .clk(clk), .reset(reset),
    .lo_tvalid(lo_tvalid), .lo_cos(lo_cos), .lo_sin(lo_sin),
    .lo_tready(lo_tready),
    .x_tvalid(x_tvalid), .xi(xi), .xq(xq), .x_tready(x_tready),
    .y_tvalid(y_tvalid), .yi(yi), .yq(yq), .y_tready(y_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int yi;
    int yq;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   outcnt = 0;
  int   out0;
  int   k;
  bit   acc;
  bit   lat_chk = 0;
  bit   stall_prev = 0;
  bit   saw_stall = 0;
  logic signed [O-1:0] pyi, pyq;

  // Complex product from the mixing equations
  function automatic exp_t model(int a, int b, int c, int s);
    exp_t e;
`ifdef SIG_MIX_CONJ_EN
    e.yi = a * c + b * s;
    e.yq = b * c - a * s;
`else
    e.yi = a * c - b * s;
    e.yq = a * s + b * c;
`endif
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic drive(bit xv, int a, int b, bit lv, int c, int s);
    x_tvalid  = xv;
    xi        = 8'(a);
    xq        = 8'(b);
    lo_tvalid = lv;
    lo_cos    = 8'(c);
    lo_sin    = 8'(s);
  endtask

  // One clock: check at negedge, update the model, then step past posedge
  task automatic tick();
    exp_t e;
    bit   rdy;
    #4;
    rdy = !reset && (q.size() < 2 || y_tready);
    chk("x_tready", x_tready, lo_tvalid & rdy);
    chk("lo_tready", lo_tready, x_tvalid & rdy);
    acc = lo_tvalid && x_tvalid && rdy;
    if (y_tvalid) begin
      if (q.size() == 0) chk("spurious_y", y_tvalid, 0);
      else begin
        chk("yi", yi, q[0].yi);
        chk("yq", yq, q[0].yq);
      end
      if (stall_prev) begin
        chk("hold_yi", yi, pyi);
        chk("hold_yq", yq, pyq);
      end
    end else if (stall_prev) begin
      chk("hold_valid", y_tvalid, 1);
    end
    if (y_tvalid && y_tready && q.size() > 0) begin
      if (lat_chk) chk("latency", cyc - q[0].cyc, 2);
      void'(q.pop_front());
      outcnt++;
    end
    stall_prev = y_tvalid && !y_tready;
    pyi = yi;
    pyq = yq;
    if (!y_tready && x_tvalid && lo_tvalid && !x_tready) saw_stall = 1;
    if (acc) begin
      e = model(xi, xq, lo_cos, lo_sin);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Single sample with exact 2-cycle latency and known result
  task automatic directed(string tag, int a, int b, int c, int s,
                          int eyi, int eyq);
    lat_chk  = 1;
    y_tready = 1;
    drive(1, a, b, 1, c, s);
    tick();
    chk({tag, "_acc"}, acc, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk({tag, "_early"}, y_tvalid, 0);
    tick();
    chk({tag, "_valid"}, y_tvalid, 1);
    chk({tag, "_yi"}, yi, eyi);
    chk({tag, "_yq"}, yq, eyq);
    tick();
    chk({tag, "_gone"}, y_tvalid, 0);
  endtask

  initial begin
    reset    = 1;
    y_tready = 1;
    drive(1, 3, 4, 1, 5, 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_yvalid", y_tvalid, 0);
    chk("rst_yi", yi, 0);
    chk("rst_yq", yq, 0);
    chk("rst_xrdy", x_tready, 0);
    chk("rst_lordy", lo_tready, 0);
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    directed("real", 100, 0, 127, 0, 12700, 0);
`ifdef SIG_MIX_CONJ_EN
    directed("imag", 0, 100, 0, 127, 12700, 0);
    directed("corner", -128, -128, -128, -128, 32768, 0);
`else
    directed("imag", 0, 100, 0, 127, -12700, 0);
    directed("corner", -128, -128, -128, -128, 0, 32768);
`endif

    // LO starved: no consumption, no output
    lat_chk = 0;
    drive(1, 5, -7, 0, 60, -60);
    repeat (4) begin
      tick();
      chk("starve_xrdy", x_tready, 0);
      chk("starve_y", y_tvalid, 0);
    end
    out0 = outcnt;
    lo_tvalid = 1;
    tick();
    chk("starve_acc", acc, 1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("starve_one", outcnt - out0, 1);

    // Six samples with output backpressure in cycles 3-7
    out0 = outcnt;
    saw_stall = 0;
    k = 1;
    for (int c = 0; c < 40 && outcnt - out0 < 6; c++) begin
      y_tready = !(c >= 3 && c <= 7);
      if (k <= 6) drive(1, k * 10, -k, 1, 100 - k, k * 3);
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      if (acc) k++;
    end
    chk("bp_count", outcnt - out0, 6);
    chk("bp_stall", saw_stall, 1);
    chk("bp_accepted", k, 7);

    // Full-rate streaming
    y_tready = 1;
    lat_chk  = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, i * 7 - 30, 25 - i * 5, 1, 90 - i * 11, i * 13 - 60);
      tick();
      chk("tput_acc", acc, 1);
      if (i >= 2) chk("tput_valid", y_tvalid, 1);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset with two samples in flight
    lat_chk  = 0;
    y_tready = 0;
    drive(1, 11, 22, 1, 33, 44);
    tick();
    drive(1, -9, 8, 1, 7, -6);
    tick();
    chk("mid_full", y_tvalid, 1);
    reset = 1;
    #1;
    chk("mid_yvalid", y_tvalid, 0);
    chk("mid_xrdy", x_tready, 0);
    chk("mid_lordy", lo_tready, 0);
    chk("mid_yi", yi, 0);
    q.delete();
    stall_prev = 0;
    @(posedge clk); #1;
    reset    = 0;
    y_tready = 1;
    lat_chk  = 1;
    out0     = outcnt;
    drive(1, 50, -50, 1, -70, 20);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("post_rst_one", outcnt - out0, 1);

    // Random traffic with random backpressure
    lat_chk = 0;
    repeat (400) begin
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128);
      y_tready = $urandom_range(0, 3) != 0;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    y_tready = 1;
    repeat (4) tick();
    chk("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
